cci_test_flow_limiter: RTL and testbench

Parametrised per-channel active-request limiter for the MPF test AFU. Sits between the FIU-side bus and the test engine. Counts lines in flight on each request channel and forces Tx almost-full when a CSR-programmed cap is near. Adds hysteresis, a drain mode and underflow detection to the earlier fixed two-channel hook.

---
 rtl/cci_test_flow_pkg.sv | 27 ++
 rtl/cci_test_flow_chan.sv | 138 +++++++++++++
 rtl/cci_test_flow_limiter.sv | 66 ++++++
 tb/tb_cci_test_flow_limiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cci_test_flow_pkg.sv
// cci_test_flow_pkg
// Shared types for the CCI test-AFU flow limiter.
//   t_flow_cnt   : default-width active-line counter (CNT_W = 10)
//   t_flow_lines : line count carried by a request/response (1..4, 0 = fence)
//   t_flow_state : per-channel throttle FSM state
// Optional feature macro used by the limiter: CCI_TEST_FLOW_PEAK_EN.

package cci_test_flow_pkg;

  localparam int FLOW_CNT_W_DEFAULT = 10;

  typedef logic [FLOW_CNT_W_DEFAULT-1:0] t_flow_cnt;
  typedef logic [2:0]                    t_flow_lines;

  typedef enum logic [1:0] {
    OPEN      = 2'd0,
    THROTTLED = 2'd1,
    DRAIN     = 2'd2,
    DONE      = 2'd3
  } t_flow_state;

  // A fence carries no data but still occupies one slot in the FIU.
  function automatic t_flow_lines flowReqLines(input t_flow_lines lines);
    return (lines == 3'd0) ? 3'd1 : lines;
  endfunction

endpackage

// File: rtl/cci_test_flow_chan.sv
// cci_test_flow_chan
// Active-line counter plus throttle/drain FSM for a single request channel.
// Macro: CCI_TEST_FLOW_PEAK_EN keeps a peak watermark of the count; when it
// is undefined peakLines is tied to 0 and the register does not exist.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   reqValid      : request accepted this cycle, reqLines lines (0 = fence)
//   rspValid      : response observed, rspLines lines retired
//   limit         : line cap, 0 disables limiting
//   drainReq      : level, request the channel to drain to zero
//   forceAlmFull  : registered almost-full force
//   activeLines   : registered in-flight count
//   drainDone     : one-cycle pulse when a drain reaches zero
//   underflowErr  : sticky, a response retired more lines than were active
//   peakLines     : peak watermark (0 without the macro)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// OPEN      | traffic flows, no force
// THROTTLED | count near the cap, force held until it falls below off_th
// DRAIN     | drain requested, force held until the count reaches zero
// DONE      | drain finished, force held until drainReq drops

module cci_test_flow_chan
  import cci_test_flow_pkg::*;
#(
  parameter int CNT_W          = 10,
  parameter int ALM_FULL_SLACK = 8,
  parameter int HYST           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqValid,
  input  t_flow_lines      reqLines,
  input  logic             rspValid,
  input  t_flow_lines      rspLines,
  input  logic [CNT_W-1:0] limit,
  input  logic             drainReq,
  output logic             forceAlmFull,
  output logic [CNT_W-1:0] activeLines,
  output logic             drainDone,
  output logic             underflowErr,
  output logic [CNT_W-1:0] peakLines
);

  localparam int SUM_W = CNT_W + 2;
  localparam int TH_W  = CNT_W + 1;

  t_flow_state      state, stateNext;
  t_flow_lines      incLines, decLines;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] nextLines;
  logic             nextUnderflow;
  logic [TH_W-1:0]  limitExt, nextExt, onTh, offTh;

  // Two's-complement sum: top bit set means the response retired more
  // lines than were in flight.
  always_comb begin
    incLines      = reqValid ? flowReqLines(reqLines) : 3'd0;
    decLines      = rspValid ? rspLines : 3'd0;
    sum           = {2'b00, activeLines} + SUM_W'(incLines) - SUM_W'(decLines);
    nextUnderflow = 1'b0;
    if (sum[SUM_W-1]) begin
      nextLines     = '0;
      nextUnderflow = 1'b1;
    end else if (|sum[SUM_W-2:CNT_W]) begin
      nextLines = '1;
    end else begin
      nextLines = sum[CNT_W-1:0];
    end
  end

  always_comb begin
    limitExt = {1'b0, limit};
    nextExt  = {1'b0, nextLines};
    onTh     = (limitExt > TH_W'(ALM_FULL_SLACK)) ? limitExt - TH_W'(ALM_FULL_SLACK) : '0;
    offTh    = (onTh > TH_W'(HYST)) ? onTh - TH_W'(HYST) : '0;
  end

  // Leaving THROTTLED also requires next < onTh. Normally implied by
  // next <= offTh; when onTh clamps to 0 it keeps force permanent instead
  // of toggling every cycle at a zero count.
  always_comb begin
    stateNext = state;
    case (state)
      OPEN: begin
        if (drainReq)
          stateNext = DRAIN;
        else if ((limit != '0) && (nextExt >= onTh))
          stateNext = THROTTLED;
      end
      THROTTLED: begin
        if (drainReq)
          stateNext = DRAIN;
        else if ((limit == '0) || ((nextExt <= offTh) && (nextExt < onTh)))
          stateNext = OPEN;
      end
      DRAIN: begin
        if (nextLines == '0)
          stateNext = DONE;
      end
      DONE: begin
        if (!drainReq)
          stateNext = OPEN;
      end
      default: stateNext = OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= OPEN;
      activeLines  <= '0;
      forceAlmFull <= 1'b0;
      drainDone    <= 1'b0;
      underflowErr <= 1'b0;
    end else begin
      state        <= stateNext;
      activeLines  <= nextLines;
      forceAlmFull <= (stateNext != OPEN);
      drainDone    <= (state == DRAIN) && (stateNext == DONE);
      underflowErr <= underflowErr | nextUnderflow;
    end
  end

`ifdef CCI_TEST_FLOW_PEAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      peakLines <= '0;
    else if (nextLines > peakLines)
      peakLines <= nextLines;
  end
`else
  assign peakLines = '0;
`endif

endmodule

// File: rtl/cci_test_flow_limiter.sv
// cci_test_flow_limiter
// Per-channel active-request limiter for the MPF test AFU. Counts lines in
// flight on each request channel and forces Tx almost-full as the
// programmed cap approaches, with hysteresis, drain mode and underflow
// detection. One cci_test_flow_chan per channel; this level only slices
// the packed buses.
// Macro: CCI_TEST_FLOW_PEAK_EN enables the peakLines watermark registers;
// undefined, peakLines reads 0.
//
// Ports (all per channel, packed [N_CHANNELS-1:0]):
//   clk, reset    : clock, asynchronous active-high reset
//   reqValid/reqLines, rspValid/rspLines : request/response traffic
//   limit         : line cap, 0 disables limiting
//   drainReq      : level drain request
//   forceAlmFull  : OR'd into Tx almost-full by the parent
//   activeLines   : in-flight count
//   drainDone     : one-cycle drain-complete pulse
//   underflowErr  : sticky underflow flag
//   peakLines     : peak watermark

module cci_test_flow_limiter
  import cci_test_flow_pkg::*;
#(
  parameter int N_CHANNELS     = 2,
  parameter int CNT_W          = 10,
  parameter int ALM_FULL_SLACK = 8,
  parameter int HYST           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CHANNELS-1:0]            reqValid,
  input  logic [N_CHANNELS-1:0][2:0]       reqLines,
  input  logic [N_CHANNELS-1:0]            rspValid,
  input  logic [N_CHANNELS-1:0][2:0]       rspLines,
  input  logic [N_CHANNELS-1:0][CNT_W-1:0] limit,
  input  logic [N_CHANNELS-1:0]            drainReq,
  output logic [N_CHANNELS-1:0]            forceAlmFull,
  output logic [N_CHANNELS-1:0][CNT_W-1:0] activeLines,
  output logic [N_CHANNELS-1:0]            drainDone,
  output logic [N_CHANNELS-1:0]            underflowErr,
  output logic [N_CHANNELS-1:0][CNT_W-1:0] peakLines
);

  for (genvar c = 0; c < N_CHANNELS; c++) begin : gChan
    cci_test_flow_chan #(
      .CNT_W          (CNT_W),
      .ALM_FULL_SLACK (ALM_FULL_SLACK),
      .HYST           (HYST)
    ) chan (
      .clk          (clk),
      .reset        (reset),
      .reqValid     (reqValid[c]),
      .reqLines     (t_flow_lines'(reqLines[c])),
      .rspValid     (rspValid[c]),
      .rspLines     (t_flow_lines'(rspLines[c])),
      .limit        (limit[c]),
      .drainReq     (drainReq[c]),
      .forceAlmFull (forceAlmFull[c]),
      .activeLines  (activeLines[c]),
      .drainDone    (drainDone[c]),
      .underflowErr (underflowErr[c]),
      .peakLines    (peakLines[c])
    );
  end

endmodule

// File: tb/tb_cci_test_flow_limiter.sv
module tb_cci_test_flow_limiter;

  localparam int NCH = 2;
  localparam int CW  = 10;
  localparam int MAXC = 1023;
`ifdef CCI_TEST_FLOW_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCH-1:0]          reqValid, rspValid, drainReq;
  logic [NCH-1:0][2:0]     reqLines, rspLines;
  logic [NCH-1:0][CW-1:0]  limit;
  logic [NCH-1:0]          forceAlmFull, drainDone, underflowErr;
  logic [NCH-1:0][CW-1:0]  activeLines, peakLines;

  always #5 clk = ~clk;

  cci_test_flow_limiter #(
    .N_CHANNELS (NCH), .CNT_W (CW), .ALM_FULL_SLACK (8), .HYST (4)
  ) dut (
    .clk (clk), .reset (reset),
    .reqValid (reqValid), .reqLines (reqLines),
    .rspValid (rspValid), .rspLines (rspLines),
    .limit (limit), .drainReq (drainReq),
    .forceAlmFull (forceAlmFull), .activeLines (activeLines),
    .drainDone (drainDone), .underflowErr (underflowErr),
    .peakLines (peakLines)
  );

  typedef struct {
    string tag;
    int    ch;
    int    active;
    int    frc;
    int    done;
    int    uf;
    int    peak;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mCnt[NCH];
  int   mPeak[NCH];
  int   mUf[NCH];

  function automatic int expPeak(input int p);
    return PEAK_ON ? p : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int c = 0; c < NCH; c++) begin
      chk({tag, " active"}, 32'(activeLines[c]), 0);
      chk({tag, " force"},  32'(forceAlmFull[c]), 0);
      chk({tag, " done"},   32'(drainDone[c]), 0);
      chk({tag, " uf"},     32'(underflowErr[c]), 0);
      chk({tag, " peak"},   32'(peakLines[c]), 0);
    end
  endtask

  task automatic checkFront();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underrun", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " active"}, 32'(activeLines[e.ch]), 32'(e.active));
      chk({e.tag, " force"},  32'(forceAlmFull[e.ch]), 32'(e.frc));
      chk({e.tag, " done"},   32'(drainDone[e.ch]), 32'(e.done));
      chk({e.tag, " uf"},     32'(underflowErr[e.ch]), 32'(e.uf));
      chk({e.tag, " peak"},   32'(peakLines[e.ch]), 32'(e.peak));
    end
  endtask

  // One clock of traffic on channel ch (other channel idle). Count,
  // underflow and peak come from the integer model; force and drainDone
  // expectations are supplied by the caller from the directed scenario.
  task automatic cyc(input string tag, input int ch, input bit rv, input int rl,
                     input bit sv, input int sl, input bit dr,
                     input int expF, input int expD);
    int inc, dec;
    reqValid = '0; rspValid = '0; drainReq = '0; reqLines = '0; rspLines = '0;
    reqValid[ch] = rv; reqLines[ch] = rl[2:0];
    rspValid[ch] = sv; rspLines[ch] = sl[2:0];
    drainReq[ch] = dr;
    inc = rv ? ((rl == 0) ? 1 : rl) : 0;
    dec = sv ? sl : 0;
    mCnt[ch] = mCnt[ch] + inc - dec;
    if (mCnt[ch] < 0) begin
      mCnt[ch] = 0;
      mUf[ch]  = 1;
    end else if (mCnt[ch] > MAXC) begin
      mCnt[ch] = MAXC;
    end
    if (mCnt[ch] > mPeak[ch]) mPeak[ch] = mCnt[ch];
    sb.push_back('{tag, ch, mCnt[ch], expF, expD, mUf[ch], expPeak(mPeak[ch])});
    @(posedge clk);
    #1;
    checkFront();
  endtask

  task automatic clearModel();
    for (int c = 0; c < NCH; c++) begin
      mCnt[c] = 0; mPeak[c] = 0; mUf[c] = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    reqValid = '0; rspValid = '0; drainReq = '0; reqLines = '0; rspLines = '0;
    limit[0] = CW'(64);
    limit[1] = '0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Ramp: force asserts on the edge the count reaches 56 (64 - 8)
    for (int i = 1; i <= 56; i++) cyc("ramp_on", 0, 1, 1, 0, 0, 0, (i >= 56) ? 1 : 0, 0);
    // Hysteresis: held through 55..53, drops at 52
    for (int i = 55; i >= 52; i--) cyc("hyst_off", 0, 0, 0, 1, 1, 0, (i > 52) ? 1 : 0, 0);

    repeat (10) cyc("ramp_down", 0, 0, 0, 1, 4, 0, 0, 0);
    cyc("to_ten", 0, 0, 0, 1, 2, 0, 0, 0);
    cyc("req4_rsp2", 0, 1, 4, 1, 2, 0, 0, 0);
    cyc("fence", 0, 1, 0, 0, 0, 0, 0, 0);

    // 13 -> 3, then a 4-line response underflows
    cyc("to_nine", 0, 0, 0, 1, 4, 0, 0, 0);
    cyc("to_five", 0, 0, 0, 1, 4, 0, 0, 0);
    cyc("to_three", 0, 0, 0, 1, 2, 0, 0, 0);
    cyc("underflow", 0, 0, 0, 1, 4, 0, 0, 0);
    cyc("uf_sticky_req", 0, 1, 2, 0, 0, 0, 0, 0);
    cyc("uf_sticky_rsp", 0, 0, 0, 1, 2, 0, 0, 0);

    // Drain from 5
    cyc("pre_drain4", 0, 1, 4, 0, 0, 0, 0, 0);
    cyc("pre_drain1", 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("drain_enter", 0, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 5; k++) cyc("drain_rsp", 0, 0, 0, 1, 1, 1, 1, (k == 5) ? 1 : 0);
    cyc("done_hold", 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("done_hold2", 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("done_exit", 0, 0, 0, 0, 0, 0, 0, 0);

    // Drain with nothing in flight: DRAIN then DONE on consecutive edges
    cyc("drain0_enter", 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("drain0_done", 0, 0, 0, 0, 0, 1, 1, 1);
    cyc("drain0_exit", 0, 0, 0, 0, 0, 0, 0, 0);

    // Limit below slack: force permanent while limit != 0
    limit[0] = CW'(5);
    repeat (3) cyc("small_limit", 0, 0, 0, 0, 0, 0, 1, 0);
    limit[0] = '0;
    cyc("limit_zero", 0, 0, 0, 0, 0, 0, 0, 0);
    limit[0] = CW'(64);

    // Channel 1 unlimited: saturate at 1023, never forced
    for (int i = 0; i < 260; i++) cyc("ch1_sat", 1, 1, 4, 0, 0, 0, 0, 0);
    cyc("ch1_sat_mix", 1, 1, 4, 1, 1, 0, 0, 0);
    cyc("ch1_sat_rsp", 1, 0, 0, 1, 3, 0, 0, 0);

    // Async reset mid-ramp
    repeat (10) cyc("pre_reset_ramp", 0, 1, 1, 0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1 checkAllZero("async_reset");
    chk("sb_empty", 32'(sb.size()), 0);
    clearModel();
    #1 reset = 1'b0;

    // Peak watermark: ramp to 30 and back
    for (int i = 0; i < 30; i++) cyc("peak_up", 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc("peak_down", 0, 0, 0, 1, 1, 0, 0, 0);
    chk("peak_final", 32'(peakLines[0]), 32'(expPeak(30)));
    chk("active_final", 32'(activeLines[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
